// File: rtl/uut_pkg.sv
// Shared Gray-counter definitions.
// Default width and a reusable binary-to-Gray helper.
package uut_pkg;

    localparam int GRAY_W = 3;

    function automatic logic [GRAY_W-1:0] bin2gray(
        input logic [GRAY_W-1:0] x
    );
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/uut_if.sv
// Gray-count output bundle.
// The counter drives it; consumers observe it.
interface uut_if #(
    parameter int WIDTH = uut_pkg::GRAY_W
);

    logic [WIDTH-1:0] y;

    modport master (output y);
    modport slave  (input  y);

endinterface

// File: rtl/uut_gray_encode.sv
// Combinational binary-to-Gray encoder.
// Each output bit is the XOR of adjacent binary bits.
module gray_encode #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);

    always_comb begin
        g = b ^ (b >> 1);
    end

endmodule

// File: rtl/uut.sv
// Free-running Gray-code counter.
// A binary count feeds a registered Gray output.
module uut
    import uut_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;

    always_comb begin
        bin_d = bin_q + 1'b1;
    end

    // Encode the next count so y lands on the same edge as the count.
    gray_encode #(
        .WIDTH(WIDTH)
    ) u_enc (
        .b(bin_d),
        .g(y_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_q <= '0;
            y_q   <= '0;
        end else begin
            bin_q <= bin_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_uut.sv
// Self-checking bench for the Gray counter.
// Expected codes queue up per edge and are checked after it.
module tb_uut;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset4 = 1'b0;

    always #5 clk = ~clk;

    uut_if #(.WIDTH(3)) bus ();
    uut_if #(.WIDTH(4)) bus4 ();

    uut #(.WIDTH(3)) dut (
        .clk(clk),
        .reset(reset),
        .y(bus.y)
    );

    uut #(.WIDTH(4)) dut4 (
        .clk(clk),
        .reset(reset4),
        .y(bus4.y)
    );

    int total = 0;
    int bad = 0;
    int pos = 0;
    logic [2:0] exp_q [$];
    logic [2:0] seq [8];

    task automatic clock_edge(input logic r);
        logic [2:0] e;
        reset = r;
        if (!r) begin
            exp_q.push_back(3'b000);
            pos = 0;
        end else begin
            exp_q.push_back(seq[pos]);
            pos = (pos + 1) % 8;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        total++;
        if (bus.y !== e) begin
            bad++;
            $display("FAIL seq: y=%b expected=%b (reset=%b)",
                     bus.y, e, r);
        end
    endtask

    task automatic test_reset();
        clock_edge(1'b0);
        clock_edge(1'b0);
    endtask

    task automatic test_release();
        clock_edge(1'b1);
        clock_edge(1'b1);
        clock_edge(1'b0);
    endtask

    task automatic test_full_cycle();
        for (int i = 0; i < 8; i++) clock_edge(1'b1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) clock_edge(1'b1);
    endtask

    task automatic test_mid_reset();
        clock_edge(1'b0);
        for (int i = 0; i < 4; i++) clock_edge(1'b1);
        total++;
        if (bus.y !== 3'b110) begin
            bad++;
            $display("FAIL pre_reset: y=%b expected=110", bus.y);
        end
        clock_edge(1'b0);
        clock_edge(1'b1);
    endtask

    task automatic test_invariant();
        logic [2:0] prev;
        prev = bus.y;
        for (int i = 0; i < 64; i++) begin
            clock_edge(1'b1);
            total++;
            if ($countones(prev ^ bus.y) != 1) begin
                bad++;
                $display("FAIL one_bit: prev=%b y=%b flips=%0d expected=1",
                         prev, bus.y, $countones(prev ^ bus.y));
            end
            prev = bus.y;
        end
    endtask

    task automatic test_width4();
        logic [15:0] seen;
        logic [3:0] prev;
        reset4 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus4.y !== 4'b0000) begin
            bad++;
            $display("FAIL w4_reset: y=%b expected=0000", bus4.y);
        end
        seen = 16'h0001;
        prev = 4'b0000;
        reset4 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ($countones(prev ^ bus4.y) != 1) begin
                bad++;
                $display("FAIL w4_step: prev=%b y=%b expected one flip",
                         prev, bus4.y);
            end
            if (i < 15) begin
                total++;
                if (seen[bus4.y]) begin
                    bad++;
                    $display("FAIL w4_repeat: y=%b expected unvisited code",
                             bus4.y);
                end
                seen[bus4.y] = 1'b1;
            end
            prev = bus4.y;
        end
        total++;
        if (seen !== 16'hffff) begin
            bad++;
            $display("FAIL w4_cover: seen=%h expected=ffff", seen);
        end
        total++;
        if (bus4.y !== 4'b0000) begin
            bad++;
            $display("FAIL w4_wrap: y=%b expected=0000", bus4.y);
        end
    endtask

    initial begin
        seq[0] = 3'b001;
        seq[1] = 3'b011;
        seq[2] = 3'b010;
        seq[3] = 3'b110;
        seq[4] = 3'b111;
        seq[5] = 3'b101;
        seq[6] = 3'b100;
        seq[7] = 3'b000;
        test_reset();
        test_release();
        test_full_cycle();
        test_wrap();
        test_mid_reset();
        test_invariant();
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
